fcs_tx_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 29 ++
 rtl/crc32_d8.sv | 26 ++
 rtl/fcs_tx_framer.sv | 188 ++++++++++++++++++
 tb/tb_fcs_tx_framer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet transmit/receive definitions.
// Holds the framer state encoding, the fixed line bytes (preamble, SFD), the reflected
// CRC-32 constants and a helper that picks one complemented FCS byte out of the CRC register.
package eth_pkg;

  // State names describe the byte currently presented on tx_data.
  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StPayload,
    StPad,
    StFcs,
    StIfg
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam int unsigned PREAMBLE_LEN    = 7;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  // FCS goes out least-significant byte first, each byte complemented.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    return ~crc[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide reflected CRC-32 step, shared by the transmit framer and the
// receive-side FCS checker.
// Ports:
//   crc_in  [31:0] current CRC register value
//   data    [7:0]  byte to fold in, processed LSB first
//   crc_out [31:0] CRC register value after the byte
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) begin
        crc_out = (crc_out >> 1) ^ CRC32_POLY_REFL;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/fcs_tx_framer.sv
// Transmit-side Ethernet framer. Wraps an upstream frame byte stream (DA through end of
// payload) with preamble and SFD, zero-pads short frames to MIN_PAYLOAD, appends the CRC-32
// FCS and enforces an inter-frame gap of IFG_BYTES idle cycles.
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   data_in         frame byte, qualified by in_valid / start_of_frame / end_of_frame
//   in_ready        byte accepted on an edge where in_valid && in_ready (combinational)
//   tx_data         registered output byte, valid when tx_valid
//   tx_start        registered, high with the first preamble byte
//   tx_end          registered, high with the last FCS byte
//   busy            high in every state except idle
module fcs_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned MIN_PAYLOAD = 60,
  parameter int unsigned IFG_BYTES   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  input  logic       start_of_frame,
  input  logic       end_of_frame,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_start,
  output logic       tx_end,
  output logic       busy
);

  localparam logic [10:0] MinCount = (MIN_PAYLOAD > 2047) ? 11'h7FF : 11'(MIN_PAYLOAD);
  localparam logic [15:0] IfgLen   = 16'(IFG_BYTES);

  tx_state_t   r_state, w_state;
  logic [15:0] r_cnt, w_cnt;        // preamble / FCS / IFG position
  logic [10:0] r_count, w_count;    // bytes between SFD and FCS, saturating
  logic [31:0] r_crc, w_crc, w_crc_next;
  logic        r_last, w_last;      // end_of_frame byte already accepted
  logic [7:0]  r_tx_data, w_tx_data;
  logic        r_tx_valid, w_tx_valid;
  logic        r_tx_start, w_tx_start;
  logic        r_tx_end, w_tx_end;
  logic        w_ready, w_accept, w_pad_emit, w_byte_emit;
  logic [7:0]  w_crc_byte;

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      // A stray non-SOF byte in idle is taken and dropped; the SOF byte is held upstream.
      StIdle:    w_ready = in_valid && !start_of_frame;
      StSfd:     w_ready = 1'b1;
      StPayload: w_ready = !r_last;
      default:   w_ready = 1'b0;
    endcase
    if (reset) w_ready = 1'b0;
  end

  assign in_ready = w_ready;
  assign w_accept = in_valid && w_ready;

  assign w_pad_emit  = ((r_state == StPayload && r_last) || r_state == StPad) &&
                       (r_count < MinCount);
  assign w_byte_emit = w_pad_emit || (w_accept && (r_state == StSfd || r_state == StPayload));
  assign w_crc_byte  = w_pad_emit ? 8'h00 : data_in;

  crc32_d8 u_crc32_d8 (
    .crc_in  (r_crc),
    .data    (w_crc_byte),
    .crc_out (w_crc_next)
  );

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_count    = r_count;
    w_crc      = r_crc;
    w_last     = r_last;
    w_tx_data  = 8'h00;
    w_tx_valid = 1'b0;
    w_tx_start = 1'b0;
    w_tx_end   = 1'b0;

    // Payload and pad bytes share one path: emit next cycle and fold into the CRC.
    if (w_byte_emit) begin
      w_crc      = w_crc_next;
      w_tx_data  = w_crc_byte;
      w_tx_valid = 1'b1;
      if (r_count != 11'h7FF) w_count = r_count + 11'd1;
    end

    case (r_state)
      StIdle: begin
        if (in_valid && start_of_frame) begin
          w_state    = StPreamble;
          w_cnt      = 16'd1;
          w_count    = 11'd0;
          w_crc      = CRC32_INIT;
          w_last     = 1'b0;
          w_tx_data  = PREAMBLE_BYTE;
          w_tx_valid = 1'b1;
          w_tx_start = 1'b1;
        end
      end
      StPreamble: begin
        w_tx_valid = 1'b1;
        if (r_cnt == 16'(PREAMBLE_LEN)) begin
          w_state   = StSfd;
          w_tx_data = SFD_BYTE;
        end else begin
          w_tx_data = PREAMBLE_BYTE;
          w_cnt     = r_cnt + 16'd1;
        end
      end
      StSfd: begin
        w_state = StPayload;
        if (w_accept) w_last = end_of_frame;
      end
      StPayload: begin
        if (!r_last) begin
          if (w_accept) w_last = end_of_frame;
        end else if (w_pad_emit) begin
          w_state = StPad;
        end else begin
          w_state    = StFcs;
          w_tx_data  = fcs_byte(r_crc, 2'd0);
          w_tx_valid = 1'b1;
          w_cnt      = 16'd1;
        end
      end
      StPad: begin
        if (!w_pad_emit) begin
          w_state    = StFcs;
          w_tx_data  = fcs_byte(r_crc, 2'd0);
          w_tx_valid = 1'b1;
          w_cnt      = 16'd1;
        end
      end
      StFcs: begin
        if (r_cnt == 16'd4) begin
          w_state = (IFG_BYTES == 0) ? StIdle : StIfg;
          w_cnt   = 16'd1;
        end else begin
          w_tx_data  = fcs_byte(r_crc, r_cnt[1:0]);
          w_tx_valid = 1'b1;
          w_tx_end   = (r_cnt == 16'd3);
          w_cnt      = r_cnt + 16'd1;
        end
      end
      StIfg: begin
        if (r_cnt >= IfgLen) w_state = StIdle;
        else                 w_cnt   = r_cnt + 16'd1;
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= 16'd0;
      r_count    <= 11'd0;
      r_crc      <= CRC32_INIT;
      r_last     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_end   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_count    <= w_count;
      r_crc      <= w_crc;
      r_last     <= w_last;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      r_tx_start <= w_tx_start;
      r_tx_end   <= w_tx_end;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_start = r_tx_start;
  assign tx_end   = r_tx_end;
  assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_fcs_tx_framer.sv
// Scoreboard bench for fcs_tx_framer: dut0 has padding disabled, dut1 uses the defaults.
module tb_fcs_tx_framer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       st;
    logic       en;
  } item_t;

  localparam int IFG = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       sof = 1'b0;
  logic       eof = 1'b0;
  logic [1:0] in_valid = 2'b00;
  logic [1:0] in_ready, tx_valid, tx_start, tx_end, busy;
  logic [7:0] tx_data [2];

  always #5 clk = ~clk;

  fcs_tx_framer #(.MIN_PAYLOAD(0), .IFG_BYTES(IFG)) u_dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid[0]),
    .start_of_frame(sof), .end_of_frame(eof), .in_ready(in_ready[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_start(tx_start[0]),
    .tx_end(tx_end[0]), .busy(busy[0])
  );

  fcs_tx_framer #(.MIN_PAYLOAD(60), .IFG_BYTES(IFG)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid[1]),
    .start_of_frame(sof), .end_of_frame(eof), .in_ready(in_ready[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_start(tx_start[1]),
    .tx_end(tx_end[1]), .busy(busy[1])
  );

  item_t       sb      [2][$];
  int          exp_len [2][$];
  int          exp_gap [2][$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          vcnt [2] = '{0, 0};
  int          gapc [2] = '{0, 0};
  int          end_cyc [2] = '{0, 0};
  bit          in_frm [2] = '{0, 0};
  bit          b2b [2] = '{0, 0};
  bit          gap_rdy [2] = '{0, 0};
  logic [31:0] fcs_sh [2] = '{0, 0};
  logic [31:0] last_fcs [2] = '{0, 0};

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endfunction

  function automatic item_t mk(input logic [7:0] d, input logic st, input logic en);
    item_t it;
    it.data = d;
    it.st   = st;
    it.en   = en;
    return it;
  endfunction

  // Reference CRC-32 (reflected, init all-ones) over a whole byte list.
  function automatic logic [31:0] crc_model(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        c = (c >> 1) ^ (((c[0] ^ b[i][k]) != 1'b0) ? 32'hEDB88320 : 32'h0);
      end
    end
    return c;
  endfunction

  // Whole expected line image of one frame, pushed when the frame is issued.
  task automatic expect_frame(input int d, input bq_t pay);
    bq_t         body;
    logic [31:0] c;
    logic [7:0]  f;
    int          minp;
    body = pay;
    minp = (d == 0) ? 0 : 60;
    while (body.size() < minp) body.push_back(8'h00);
    c = crc_model(body);
    for (int i = 0; i < 7; i++) sb[d].push_back(mk(8'h55, i == 0, 1'b0));
    sb[d].push_back(mk(8'hD5, 1'b0, 1'b0));
    foreach (body[i]) sb[d].push_back(mk(body[i], 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      f = ~c[8*k +: 8];
      sb[d].push_back(mk(f, 1'b0, k == 3));
    end
    exp_len[d].push_back(body.size() + 12);
  endtask

  task automatic wait_accept(input int d);
    for (int g = 0; g < 500; g++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_checks++;
    $display("FAIL accept_timeout%0d: got no in_ready, expected handshake within 500 cycles", d);
  endtask

  task automatic send_frame(input int d, input bq_t pay, input int stall_at,
                            input int stall_len, input bit rnd);
    int gap;
    int k;
    gap = 0;
    expect_frame(d, pay);
    foreach (pay[i]) begin
      data_in     = pay[i];
      sof         = (i == 0);
      eof         = (i == pay.size() - 1);
      in_valid[d] = 1'b1;
      wait_accept(d);
      in_valid[d] = 1'b0;
      sof         = 1'b0;
      eof         = 1'b0;
      if (i < pay.size() - 1) begin
        if (i == stall_at) k = stall_len;
        else if (rnd && $urandom_range(0, 3) == 0) k = int'($urandom_range(1, 3));
        else k = 0;
        gap += k;
        repeat (k) @(posedge clk);
        if (k > 0) #1;
      end
    end
    exp_gap[d].push_back(gap);
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy[d] && sb[d].size() == 0) return;
    end
    n_checks++;
    $display("FAIL idle_timeout%0d: got busy=%0b pending=%0d, expected idle", d, busy[d],
             sb[d].size());
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_txdata%0d", tag, d), tx_data[d], 0);
      chk($sformatf("%s_txvalid%0d", tag, d), tx_valid[d], 0);
      chk($sformatf("%s_txstart%0d", tag, d), tx_start[d], 0);
      chk($sformatf("%s_txend%0d", tag, d), tx_end[d], 0);
      chk($sformatf("%s_busy%0d", tag, d), busy[d], 0);
      chk($sformatf("%s_inready%0d", tag, d), in_ready[d], 0);
    end
  endtask

  // Monitor: pops and compares every presented byte; checks per-frame length and stall gaps.
  always @(negedge clk) begin
    item_t e;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        in_frm[d] = 1'b0;
        continue;
      end
      if (tx_start[d]) begin
        if (b2b[d]) begin
          chk($sformatf("b2b_start_dist%0d", d), cyc - end_cyc[d], IFG + 2);
          chk($sformatf("ifg_sof_ready%0d", d), gap_rdy[d], 0);
        end
        in_frm[d] = 1'b1;
        vcnt[d]   = 0;
        gapc[d]   = 0;
      end
      if (!in_frm[d] && in_valid[d] && sof && in_ready[d]) gap_rdy[d] = 1'b1;
      if (tx_valid[d]) begin
        vcnt[d]++;
        fcs_sh[d] = {fcs_sh[d][23:0], tx_data[d]};
        if (sb[d].size() == 0) begin
          n_checks++;
          $display("FAIL tx%0d_unexpected: got byte 0x%0h, expected no output", d, tx_data[d]);
        end else begin
          e = sb[d].pop_front();
          chk($sformatf("tx%0d_byte", d), {tx_data[d], tx_start[d], tx_end[d]}, e);
        end
      end else if (in_frm[d]) begin
        gapc[d]++;
      end
      if (tx_end[d] && in_frm[d]) begin
        last_fcs[d] = fcs_sh[d];
        if (exp_len[d].size() == 0 || exp_gap[d].size() == 0) begin
          n_checks++;
          $display("FAIL frame%0d_unexpected_end: got tx_end, expected no frame", d);
        end else begin
          chk($sformatf("frame%0d_valid_cycles", d), vcnt[d], exp_len[d].pop_front());
          chk($sformatf("frame%0d_stall_cycles", d), gapc[d], exp_gap[d].pop_front());
        end
        in_frm[d]  = 1'b0;
        end_cyc[d] = cyc;
        gap_rdy[d] = 1'b0;
      end
    end
  end

  initial begin
    bq_t p;
    bq_t p2;
    int  d;
    int  len;

    for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));

    // Reset state; a stray byte is offered so in_ready must be held low by reset alone.
    in_valid = 2'b11;
    #3;
    chk_zero("por");
    in_valid = 2'b00;
    #19 reset = 1'b0;
    @(posedge clk);
    #1;

    // "123456789", no padding.
    send_frame(0, p, -1, 0, 1'b0);
    wait_idle(0);
    chk("s1_fcs", last_fcs[0], 32'h2639F4CB);

    // Same frame with a 3-cycle stall after 0x34.
    send_frame(0, p, 3, 3, 1'b0);
    wait_idle(0);
    chk("stall_fcs", last_fcs[0], 32'h2639F4CB);

    // One-byte frame padded to 60.
    p2 = {};
    p2.push_back(8'hAB);
    send_frame(1, p2, -1, 0, 1'b0);
    wait_idle(1);

    // Reset while FCS byte 2 is on the line.
    send_frame(0, p, -1, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("fcs2_before_reset", tx_data[0], 8'hF4);
    reset    = 1'b1;
    in_valid = 2'b11;
    #1;
    chk_zero("mid_fcs_reset");
    in_valid = 2'b00;
    sb[0].delete();
    exp_len[0].delete();
    exp_gap[0].delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    send_frame(0, p, -1, 0, 1'b0);
    wait_idle(0);
    chk("post_reset_fcs", last_fcs[0], 32'h2639F4CB);

    // Back-to-back: second SOF is presented while the first frame is still finishing.
    send_frame(0, p, -1, 0, 1'b0);
    b2b[0] = 1'b1;
    p2 = {};
    for (int i = 0; i < 5; i++) p2.push_back(8'($urandom));
    send_frame(0, p2, -1, 0, 1'b0);
    wait_idle(0);
    b2b[0] = 1'b0;

    // Stray non-SOF byte in idle: taken, nothing transmitted.
    @(posedge clk);
    #1;
    data_in     = 8'h77;
    in_valid[0] = 1'b1;
    @(negedge clk);
    chk("stray_ready", in_ready[0], 1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_txvalid", tx_valid[0], 0);
      chk("stray_busy", busy[0], 0);
    end

    // Random frames with random stalls on both instances.
    for (int f = 0; f < 8; f++) begin
      d   = f % 2;
      len = int'($urandom_range(1, 80));
      p2  = {};
      for (int i = 0; i < len; i++) p2.push_back(8'($urandom));
      send_frame(d, p2, -1, 0, 1'b1);
      wait_idle(d);
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sb_drain%0d", k), sb[k].size(), 0);
      chk($sformatf("len_drain%0d", k), exp_len[k].size(), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish within 100000 cycles");
    $fatal(1);
  end

endmodule
